// File: rtl/operand2_imm_encoder.sv
// Sequential search for the ARM rotated-immediate {rot, imm8} encoding of a
// 32-bit constant; reports the smallest rotation or that none exists.
module operand2_imm_encoder #(
  parameter int N     = 32,
  parameter int IMM_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  value_in,
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic [11:0]   imm12_out,
  output logic          carry_out,
  output logic          carry_used
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_work;
  logic [N-1:0]   r_orig;
  logic [3:0]     r_cnt;
  logic           r_valid;
  logic [11:0]    r_imm12;
  logic           r_carry;
  logic           r_cused;
  logic           w_hit;
  logic           w_last;
  logic           w_rot_nz;

  assign w_hit    = (r_work[N-1:IMM_W] == '0);
  assign w_last   = (r_cnt == 4'hF);
  assign w_rot_nz = (r_cnt != 4'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_SEARCH;
      S_SEARCH: if (w_hit || w_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Rotating left by 2 per step undoes imm8 ROR 2*cnt, so the
  // first hit is the smallest legal rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_orig  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_imm12 <= '0;
      r_carry <= 1'b0;
      r_cused <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work <= value_in;
            r_orig <= value_in;
            r_cnt  <= '0;
          end
        end
        S_SEARCH: begin
          if (w_hit) begin
            r_valid <= 1'b1;
            r_imm12 <= {r_cnt, r_work[IMM_W-1:0]};
            r_carry <= w_rot_nz & r_orig[N-1];
            r_cused <= w_rot_nz;
          end else if (w_last) begin
            r_valid <= 1'b0;
            r_imm12 <= '0;
            r_carry <= 1'b0;
            r_cused <= 1'b0;
          end else begin
            r_work <= {r_work[N-3:0], r_work[N-1:N-2]};
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = (r_state == S_SEARCH) || (r_state == S_DONE);
  assign done       = (r_state == S_DONE);
  assign valid      = r_valid;
  assign imm12_out  = r_imm12;
  assign carry_out  = r_carry;
  assign carry_used = r_cused;

endmodule
